uart_rx_dma: RTL and testbench

//  RX-side DMA engine that sits directly downstream of uart_core. On dma_rx_req it reads the RX data register
//  (offset 0x00) over the core's register port. Received bytes are packed little-endian into 32-bit words and

---
 rtl/uart_rx_dma_pkg.sv | 20 ++
 rtl/uart_rx_dma_packer.sv | 55 +++++
 rtl/uart_rx_dma.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_rx_dma.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_dma_pkg.sv
// rtl/uart_rx_dma_pkg.sv - shared state type, register default and lane helper for the UART RX DMA engine
package uart_rx_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    READ,
    CAPTURE,
    WRITE,
    DONE
  } state_e;

  localparam logic [31:0] RX_DATA_ADDR_DEFAULT = 32'h0000_0000;

  // One-hot byte enable for a byte lane within a 32-bit word
  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/uart_rx_dma_packer.sv
// rtl/uart_rx_dma_packer.sv - little-endian byte-to-word packer with per-lane byte enables
module uart_rx_dma_packer
  import uart_rx_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_byte,
  input  logic        clear,
  output logic        full,
  output logic        empty,
  output logic [31:0] data_out,
  output logic [3:0]  be_out
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  be_q, be_d;

  // Next packer contents; clear has priority so an abort can discard a byte in flight
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    be_d   = be_q;
    if (clear) begin
      lane_d = 2'd0;
      word_d = 32'h0;
      be_d   = 4'h0;
    end else if (push) begin
      word_d[{lane_q, 3'b000} +: 8] = push_byte;
      be_d   = be_q | lane_be(lane_q);
      lane_d = lane_q + 2'd1;
    end
  end

  // Packer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= 2'd0;
      word_q <= 32'h0;
      be_q   <= 4'h0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= be_d;
    end
  end

  // full looks ahead: the byte being pushed now completes the word
  assign full     = push & (lane_q == 2'd3);
  assign empty    = (be_q == 4'h0);
  assign data_out = word_q;
  assign be_out   = be_q;

endmodule

// File: rtl/uart_rx_dma.sv
// rtl/uart_rx_dma.sv - UART RX DMA engine; idle-timeout flush enabled by UART_RX_DMA_TIMEOUT_EN
module uart_rx_dma
  import uart_rx_dma_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter int          LEN_W        = 16,
  parameter logic [31:0] RX_DATA_ADDR = RX_DATA_ADDR_DEFAULT,
  parameter int          TIMEOUT_CYC  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              irq_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              timed_out,
  output logic [LEN_W-1:0]  byte_count,
  output logic              irq,
  input  logic              dma_rx_req,
  output logic [31:0]       m_reg_addr,
  output logic [31:0]       m_reg_wdata,
  output logic              m_reg_we,
  output logic              m_reg_re,
  output logic [3:0]        m_reg_be,
  input  logic [31:0]       m_reg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              in_busy, start_ok, flush_req;
  logic              pk_push, pk_clear, pk_full, pk_empty;
  logic [31:0]       pk_data;
  logic [3:0]        pk_be;
  logic              unused_bits;

`ifdef UART_RX_DMA_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              flush_q, flush_d;
  logic              tmo_q, tmo_d;
  assign flush_req = flush_q;
  assign timed_out = tmo_q;
`else
  assign flush_req = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign in_busy  = (state_q == WAIT_REQ) || (state_q == READ) ||
                    (state_q == CAPTURE)  || (state_q == WRITE);
  assign start_ok = start & ~abort & ~in_busy;

  uart_rx_dma_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .push      (pk_push),
    .push_byte (m_reg_rdata[7:0]),
    .clear     (pk_clear),
    .full      (pk_full),
    .empty     (pk_empty),
    .data_out  (pk_data),
    .be_out    (pk_be)
  );

  // Transfer FSM: next state, counters and sticky status; abort overrides everything while busy
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    pk_push   = 1'b0;
    pk_clear  = 1'b0;
`ifdef UART_RX_DMA_TIMEOUT_EN
    idle_d    = idle_q;
    flush_d   = flush_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_ok) begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          cnt_d     = '0;
          len_d     = length;
          addr_d    = {base_addr[ADDR_W-1:2], 2'b00};
          pk_clear  = 1'b1;
`ifdef UART_RX_DMA_TIMEOUT_EN
          idle_d    = '0;
          flush_d   = 1'b0;
          tmo_d     = 1'b0;
`endif
          if (length == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_REQ;
          end
        end
      end
      WAIT_REQ: begin
        if (dma_rx_req) begin
          state_d = READ;
        end
`ifdef UART_RX_DMA_TIMEOUT_EN
        else if (cnt_q != '0) begin
          if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
            idle_d = '0;
            if (pk_empty) begin
              state_d = DONE;
              done_d  = 1'b1;
              tmo_d   = 1'b1;
            end else begin
              state_d = WRITE;
              flush_d = 1'b1;
            end
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
`endif
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        pk_push = 1'b1;
        if (cnt_q != len_q) begin
          cnt_d = cnt_q + LEN_W'(1);
        end
`ifdef UART_RX_DMA_TIMEOUT_EN
        idle_d = '0;
`endif
        if (pk_full || ((cnt_q + LEN_W'(1)) == len_q)) begin
          state_d = WRITE;
        end else begin
          state_d = WAIT_REQ;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          pk_clear = 1'b1;
          addr_d   = addr_q + ADDR_W'(4);
          if ((cnt_q == len_q) || flush_req) begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef UART_RX_DMA_TIMEOUT_EN
            tmo_d   = flush_q;
            flush_d = 1'b0;
`endif
          end else begin
            state_d = WAIT_REQ;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && in_busy) begin
      state_d   = IDLE;
      pk_push   = 1'b0;
      pk_clear  = 1'b1;
      aborted_d = 1'b1;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
`ifdef UART_RX_DMA_TIMEOUT_EN
      idle_d    = idle_q;
      flush_d   = 1'b0;
      tmo_d     = tmo_q;
`endif
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef UART_RX_DMA_TIMEOUT_EN
      idle_q    <= '0;
      flush_q   <= 1'b0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
`ifdef UART_RX_DMA_TIMEOUT_EN
      idle_q    <= idle_d;
      flush_q   <= flush_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign busy        = in_busy;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign byte_count  = cnt_q;
  assign irq         = done_q & irq_en;

  assign m_reg_addr  = RX_DATA_ADDR;
  assign m_reg_wdata = 32'h0;
  assign m_reg_we    = 1'b0;
  assign m_reg_be    = 4'hF;
  assign m_reg_re    = (state_q == READ);

  assign mem_addr    = addr_q;
  assign mem_wdata   = pk_data;
  assign mem_be      = pk_be;
  assign mem_we      = (state_q == WRITE);

  // Upper read-data bits, ignored address bits and the timeout-only signals have no use here
  assign unused_bits = ^{m_reg_rdata[31:8], base_addr[1:0], pk_empty, (TIMEOUT_CYC == 0)};

endmodule

// File: tb/tb_uart_rx_dma.sv
// tb/tb_uart_rx_dma.sv - self-checking bench for uart_rx_dma: vector table plus scoreboard of memory writes
`timescale 1ns/1ps
module tb_uart_rx_dma;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int TMO    = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              irq_en = 1'b0;
  logic              busy, done, aborted, timed_out, irq;
  logic [LEN_W-1:0]  byte_count;
  logic              dma_rx_req = 1'b0;
  logic [31:0]       m_reg_addr, m_reg_wdata;
  logic              m_reg_we, m_reg_re;
  logic [3:0]        m_reg_be;
  logic [31:0]       m_reg_rdata = 32'h0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_we;
  logic              mem_ready = 1'b1;

  uart_rx_dma #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RX_DATA_ADDR(32'h0), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .length(length), .irq_en(irq_en), .busy(busy), .done(done), .aborted(aborted),
    .timed_out(timed_out), .byte_count(byte_count), .irq(irq), .dma_rx_req(dma_rx_req),
    .m_reg_addr(m_reg_addr), .m_reg_wdata(m_reg_wdata), .m_reg_we(m_reg_we),
    .m_reg_re(m_reg_re), .m_reg_be(m_reg_be), .m_reg_rdata(m_reg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    int          len;
    logic [7:0]  b0;
    logic [7:0]  step;
    logic        irq_en;
    logic [31:0] first_addr;
    logic [31:0] first_data;
    logic [3:0]  last_be;
    int          n_writes;
  } vec_t;

  wr_t         exp_q[$];
  logic [7:0]  rx_fifo[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [3:0]  wr_be_log[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  logic [31:0] rnd;
  logic [7:0]  rx_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // uart_core model: one-cycle read latency, request level follows FIFO occupancy
  always @(posedge clk) begin
    if (m_reg_re && rx_fifo.size() != 0) begin
      rnd  = $urandom;
      rx_b = rx_fifo.pop_front();
      m_reg_rdata <= {rnd[31:8], rx_b};
    end
    dma_rx_req <= (rx_fifo.size() != 0);
  end

  // Memory-side monitor: each accepted write is popped from the scoreboard and compared
  always @(negedge clk) begin
    wr_t e;
    if (m_reg_re) n_rd++;
    if (mem_we && mem_ready && !rst) begin
      n_wr++;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
      wr_be_log.push_back(mem_be);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: actual addr 0x%0h data 0x%0h be 0x%0h, required no write",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_be", {28'h0, mem_be}, {28'h0, e.be});
      end
    end
  end

  task automatic push_bytes(input int n, input logic [7:0] b0, input logic [7:0] step);
    for (int i = 0; i < n; i++) rx_fifo.push_back(8'(b0 + step * i));
  endtask

  // Reference packing: lane i%4, flush on full word or last byte
  task automatic gen_writes(input logic [31:0] base, input int n, input logic [7:0] b0,
                            input logic [7:0] step);
    wr_t         w;
    logic [31:0] a;
    a = {base[31:2], 2'b00};
    w.data = 32'h0;
    w.be = 4'h0;
    for (int i = 0; i < n; i++) begin
      w.data[8*(i%4) +: 8] = 8'(b0 + step * i);
      w.be[i%4] = 1'b1;
      if ((i % 4) == 3 || i == n - 1) begin
        w.addr = a;
        exp_q.push_back(w);
        a = a + 32'd4;
        w.data = 32'h0;
        w.be = 4'h0;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input int len);
    base_addr = base;
    length = 16'(len);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    for (int i = 0; i < max && !done; i++) cyc(1);
    chk(name, done, 1);
  endtask

  task automatic wait_we(input string name, input int max);
    for (int i = 0; i < max && !mem_we; i++) cyc(1);
    chk(name, mem_we, 1);
  endtask

  task automatic wait_count(input string name, input int n, input int max);
    for (int i = 0; i < max && byte_count != 16'(n); i++) cyc(1);
    chk(name, byte_count, n);
  endtask

  vec_t        vecs[5];
  int          rd0, wr0, idx0, changes, lat;
  logic [31:0] sa, sd;
  logic [3:0]  sb;

  initial begin
    vecs[0] = '{32'h0000_1000, 4, 8'h11, 8'h11, 1'b1, 32'h0000_1000, 32'h4433_2211, 4'hF, 1};
    vecs[1] = '{32'h0000_2000, 6, 8'h01, 8'h01, 1'b0, 32'h0000_2000, 32'h0403_0201, 4'h3, 2};
    vecs[2] = '{32'h0000_3003, 3, 8'hA0, 8'h05, 1'b1, 32'h0000_3000, 32'h00AA_A5A0, 4'h7, 1};
    vecs[3] = '{32'hFFFF_FFF8, 9, 8'hF0, 8'h01, 1'b0, 32'hFFFF_FFF8, 32'hF3F2_F1F0, 4'h1, 3};
    vecs[4] = '{32'h0000_0040, 1, 8'h5A, 8'h00, 1'b1, 32'h0000_0040, 32'h0000_005A, 4'h1, 1};

    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_m_reg_re", m_reg_re, 0);
    chk("rst_m_reg_we", m_reg_we, 0);
    chk("rst_m_reg_be", m_reg_be, 4'hF);
    chk("rst_m_reg_addr", m_reg_addr, 32'h0);
    chk("rst_m_reg_wdata", m_reg_wdata, 32'h0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    cyc(2);

    for (int v = 0; v < 5; v++) begin
      rd0 = n_rd;
      wr0 = n_wr;
      idx0 = wr_data_log.size();
      irq_en = vecs[v].irq_en;
      push_bytes(vecs[v].len, vecs[v].b0, vecs[v].step);
      gen_writes(vecs[v].base, vecs[v].len, vecs[v].b0, vecs[v].step);
      pulse_start(vecs[v].base, vecs[v].len);
      wait_done($sformatf("v%0d_done", v), 400);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_byte_count", v), byte_count, vecs[v].len);
      chk($sformatf("v%0d_irq", v), irq, vecs[v].irq_en);
      chk($sformatf("v%0d_reads", v), n_rd - rd0, vecs[v].len);
      chk($sformatf("v%0d_writes", v), n_wr - wr0, vecs[v].n_writes);
      chk($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
      if (wr_data_log.size() > idx0) begin
        chk($sformatf("v%0d_first_addr", v), wr_addr_log[idx0], vecs[v].first_addr);
        chk($sformatf("v%0d_first_data", v), wr_data_log[idx0], vecs[v].first_data);
        chk($sformatf("v%0d_last_be", v), wr_be_log[wr_be_log.size()-1], vecs[v].last_be);
      end else begin
        chk($sformatf("v%0d_write_present", v), 0, 1);
      end
      exp_q.delete();
      cyc(2);
    end

    // mem_ready stalled: write request must hold steady and be accepted exactly once
    irq_en = 1'b0;
    mem_ready = 1'b0;
    wr0 = n_wr;
    push_bytes(4, 8'hD1, 8'h01);
    gen_writes(32'h0000_4000, 4, 8'hD1, 8'h01);
    pulse_start(32'h0000_4000, 4);
    wait_we("stall_we_seen", 200);
    sa = mem_addr;
    sd = mem_wdata;
    sb = mem_be;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (!mem_we || mem_addr != sa || mem_wdata != sd || mem_be != sb) changes++;
    end
    chk("stall_stable", changes, 0);
    chk("stall_no_accept", n_wr - wr0, 0);
    mem_ready = 1'b1;
    wait_done("stall_done", 20);
    chk("stall_one_write", n_wr - wr0, 1);
    exp_q.delete();
    cyc(2);

    // abort after 5 of 8 bytes: first word written, partial word discarded
    irq_en = 1'b1;
    wr0 = n_wr;
    push_bytes(5, 8'h31, 8'h01);
    gen_writes(32'h0000_6000, 4, 8'h31, 8'h01);
    pulse_start(32'h0000_6000, 8);
    wait_count("abort_count5", 5, 200);
    cyc(2);
    pulse_abort();
    chk("abort_busy", busy, 0);
    chk("abort_aborted", aborted, 1);
    chk("abort_done", done, 0);
    chk("abort_irq", irq, 0);
    cyc(20);
    chk("abort_writes", n_wr - wr0, 1);
    chk("abort_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // abort while a write is stalled: the write is dropped
    mem_ready = 1'b0;
    wr0 = n_wr;
    push_bytes(4, 8'h81, 8'h01);
    pulse_start(32'h0000_7000, 4);
    wait_we("abort_wr_we_seen", 200);
    pulse_abort();
    chk("abort_wr_we", mem_we, 0);
    chk("abort_wr_aborted", aborted, 1);
    mem_ready = 1'b1;
    cyc(5);
    chk("abort_wr_writes", n_wr - wr0, 0);

    // zero length: done next cycle, no bus activity
    irq_en = 1'b1;
    rd0 = n_rd;
    wr0 = n_wr;
    pulse_start(32'h0000_8000, 0);
    chk("len0_done", done, 1);
    chk("len0_irq", irq, 1);
    chk("len0_busy", busy, 0);
    chk("len0_aborted_cleared", aborted, 0);
    cyc(5);
    chk("len0_reads", n_rd - rd0, 0);
    chk("len0_writes", n_wr - wr0, 0);

    // start and abort together: abort wins, nothing starts
    abort = 1'b1;
    pulse_start(32'h0000_8000, 4);
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_done_kept", done, 1);
    chk("start_abort_aborted", aborted, 0);

    // start while busy is ignored: original base and length stay in force
    irq_en = 1'b0;
    pulse_start(32'h0000_5000, 4);
    cyc(3);
    chk("restart_busy", busy, 1);
    pulse_start(32'h0000_9000, 2);
    push_bytes(4, 8'hC1, 8'h01);
    gen_writes(32'h0000_5000, 4, 8'hC1, 8'h01);
    wait_done("restart_done", 200);
    chk("restart_count", byte_count, 4);
    chk("restart_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    cyc(2);

    // idle timeout with 3 of 8 bytes
    wr0 = n_wr;
    push_bytes(3, 8'h71, 8'h10);
`ifdef UART_RX_DMA_TIMEOUT_EN
    gen_writes(32'h0000_A000, 3, 8'h71, 8'h10);
    pulse_start(32'h0000_A000, 8);
    wait_count("tmo_count3", 3, 200);
    lat = 0;
    for (int i = 0; i < 200 && !mem_we; i++) begin
      cyc(1);
      lat++;
    end
    chk("tmo_we_seen", mem_we, 1);
    chk("tmo_latency_near_50", (lat >= 45 && lat <= 55), 1);
    wait_done("tmo_done", 20);
    chk("tmo_timed_out", timed_out, 1);
    chk("tmo_count", byte_count, 3);
    chk("tmo_writes", n_wr - wr0, 1);
    chk("tmo_sb_empty", exp_q.size(), 0);
    exp_q.delete();
`else
    pulse_start(32'h0000_A000, 8);
    wait_count("notmo_count3", 3, 200);
    cyc(3 * TMO);
    chk("notmo_busy", busy, 1);
    chk("notmo_timed_out", timed_out, 0);
    chk("notmo_writes", n_wr - wr0, 0);
    pulse_abort();
    chk("notmo_aborted", aborted, 1);
`endif
    cyc(2);

    // reset mid-write: outputs return to reset values and no write completes
    mem_ready = 1'b0;
    wr0 = n_wr;
    push_bytes(4, 8'hE1, 8'h01);
    pulse_start(32'h0000_B000, 4);
    wait_we("rst_mid_we_seen", 200);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", byte_count, 0);
    chk("rst_mid_be", mem_be, 0);
    rx_fifo.delete();
    cyc(2);
    rst = 1'b0;
    mem_ready = 1'b1;
    cyc(10);
    chk("rst_mid_writes", n_wr - wr0, 0);
    chk("rst_mid_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
